// File: rtl/accum_ram_pkg.sv
// accum_ram_pkg
//   Shared types and lane arithmetic for the accumulating RAM.
//   - wr_mode_e : write command encoding (overwrite / add-wrap / add-sat / clear)
//   - lane_op   : resolves one lane from the write mode, the old lane value
//                 and the addend lane. It works on a MAX_LANE_W container so
//                 that any lane width up to MAX_LANE_W can share one function.
package accum_ram_pkg;

  typedef enum logic [1:0] {
    WR_OVERWRITE = 2'b00,
    WR_ADD       = 2'b01,
    WR_ADD_SAT   = 2'b10,
    WR_CLEAR     = 2'b11
  } wr_mode_e;

  localparam int unsigned MAX_LANE_W = 64;

  // Operands must be zero-extended from lane_w bits. The extra sum bit
  // catches the carry out of the lane for saturation; it never leaks into
  // a neighbouring lane because each lane is resolved separately.
  function automatic logic [MAX_LANE_W-1:0] lane_op(
    input wr_mode_e                mode,
    input logic [MAX_LANE_W-1:0]   old_lane,
    input logic [MAX_LANE_W-1:0]   addend,
    input int unsigned             lane_w
  );
    logic [MAX_LANE_W:0] sum;
    logic [MAX_LANE_W:0] mask;
    logic [MAX_LANE_W:0] pick;
    mask = ((MAX_LANE_W+1)'(1) << lane_w) - (MAX_LANE_W+1)'(1);
    sum  = {1'b0, old_lane} + {1'b0, addend};
    case (mode)
      WR_OVERWRITE: pick = {1'b0, addend};
      WR_ADD:       pick = sum & mask;
      WR_ADD_SAT:   pick = (sum > mask) ? mask : sum;
      WR_CLEAR:     pick = '0;
      default:      pick = '0;
    endcase
    return MAX_LANE_W'(pick);
  endfunction

endpackage

// File: rtl/accum_ram_lane.sv
// accum_lane
//   Combinational single-lane resolver.
//   Ports:
//     mode     in  write command mode
//     old_lane in  current lane value (array or forwarded)
//     addend   in  lane of the write data
//     new_lane out resolved lane value
module accum_lane
  import accum_ram_pkg::*;
#(
  parameter int LANE_W = 32
) (
  input  wr_mode_e          mode,
  input  logic [LANE_W-1:0] old_lane,
  input  logic [LANE_W-1:0] addend,
  output logic [LANE_W-1:0] new_lane
);

  logic [MAX_LANE_W-1:0] res;

  assign res      = lane_op(mode, MAX_LANE_W'(old_lane), MAX_LANE_W'(addend), LANE_W);
  assign new_lane = LANE_W'(res);

endmodule

// File: rtl/accum_ram.sv
// accum_ram
//   Accumulating RAM: DEPTH words of DATA_W bits, split into LANE_W lanes.
//   One write/accumulate port and one read port, usable in the same cycle.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     wr_en/wr_mode        write command valid / mode (overwrite, add, add-sat, clear)
//     wr_addr/wr_data      write address / data or addend
//     rd_en/rd_addr        read command valid / address
//     rd_data/rd_valid     read result, valid one cycle after rd_en
//   Pipeline: a write accepted at edge T latches the old word (array or the
//   in-flight pending word) and the addend; during the following cycle the
//   lanes resolve combinationally into p_data, which commits at edge T+1.
//   Reads and later writes forward p_data when they hit the pending address.
module accum_ram
  import accum_ram_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LANE_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int LANES = DATA_W / LANE_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  wr_mode_e          p_mode;
  logic [DATA_W-1:0] p_addend;
  logic [DATA_W-1:0] p_old;
  logic [DATA_W-1:0] p_data;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic [DATA_W-1:0] old_sel;
  logic [DATA_W-1:0] rd_sel;

  // Only matters when DEPTH is not a power of two.
  assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));
  assign wr_ok       = wr_en && wr_in_range;

  // The pending word is written to the array on the same edge that samples
  // these muxes, so the array still holds the stale value: forward p_data.
  always_comb begin
    old_sel = '0;
    if (p_valid && (p_addr == wr_addr)) begin
      old_sel = p_data;
    end else if (wr_in_range) begin
      old_sel = mem[wr_addr];
    end
  end

  always_comb begin
    rd_sel = '0;
    if (!rd_in_range) begin
      rd_sel = '0;
    end else if (p_valid && (p_addr == rd_addr)) begin
      rd_sel = p_data;
    end else begin
      rd_sel = mem[rd_addr];
    end
  end

  // ---- stage boundary: command capture (old word + addend) ----
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      p_addr   <= wr_addr;
      p_mode   <= wr_mode_e'(wr_mode);
      p_addend <= wr_data;
      p_old    <= old_sel;
    end
  end

  // ---- lane resolution of the pending command ----
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    accum_lane #(
      .LANE_W (LANE_W)
    ) u_lane (
      .mode     (p_mode),
      .old_lane (p_old[i*LANE_W +: LANE_W]),
      .addend   (p_addend[i*LANE_W +: LANE_W]),
      .new_lane (p_data[i*LANE_W +: LANE_W])
    );
  end

  // ---- stage boundary: array commit ----
  // p_valid drops asynchronously in reset, so an in-flight commit is lost
  // while committed contents are kept.
  always_ff @(posedge clk) begin
    if (p_valid) begin
      mem[p_addr] <= p_data;
    end
  end

  // ---- stage boundary: control and read register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      p_valid  <= wr_ok;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_accum_ram.sv
module tb_accum_ram;

  localparam int DW = 512;
  localparam int AW = 6;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [1:0]    wr_mode;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int checks = 0;
  int errors = 0;

  accum_ram #(
    .DATA_W (DW),
    .LANE_W (32),
    .DEPTH  (64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_mode  (wr_mode),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [31:0] l1, input logic [31:0] l0);
    logic [DW-1:0] w;
    w        = '0;
    w[63:32] = l1;
    w[31:0]  = l0;
    return w;
  endfunction

  // Apply one cycle of commands, return 1 time unit after the sampling edge.
  task automatic drive(input logic we, input logic [1:0] mode, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    wr_en   = we;
    wr_mode = mode;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd1);
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd1);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid);
    end
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
    end
    rst_n = 1'b1;
    idle();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_overwrite();
    drive(1'b1, 2'b00, 6'd5, mk(32'h1, 32'h2), 1'b0, '0);
    idle();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL ow_idle_valid: got %b expected 0", rd_valid);
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd5);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL ow_rd_valid: got %b expected 1", rd_valid);
    end
    checks++;
    if (rd_data !== mk(32'h1, 32'h2)) begin
      errors++; $display("FAIL ow_rd_data: got %h expected %h", rd_data, mk(32'h1, 32'h2));
    end
    idle();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL ow_valid_pulse: got %b expected 0", rd_valid);
    end
    checks++;
    if (rd_data !== mk(32'h1, 32'h2)) begin
      errors++; $display("FAIL ow_rd_hold: got %h expected %h", rd_data, mk(32'h1, 32'h2));
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 6'd3, mk(32'd7, 32'd10), 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b01, 6'd3, mk(32'd0, 32'd5), 1'b0, '0);
    // Read right after the last add: still in the pending register.
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd3);
    checks++;
    if (rd_data !== mk(32'd7, 32'd25)) begin
      errors++; $display("FAIL b2b_fwd_read: got %h expected %h", rd_data, mk(32'd7, 32'd25));
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd3);
    checks++;
    if (rd_data !== mk(32'd7, 32'd25)) begin
      errors++; $display("FAIL b2b_array_read: got %h expected %h", rd_data, mk(32'd7, 32'd25));
    end
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_valid: got %b expected 1", rd_valid);
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 2'b00, 6'd11, mk(32'h1234, 32'hFFFF_FFF0), 1'b0, '0);
    drive(1'b1, 2'b00, 6'd12, mk(32'h1234, 32'hFFFF_FFF0), 1'b0, '0);
    drive(1'b1, 2'b01, 6'd11, mk(32'h0, 32'h20), 1'b0, '0);
    drive(1'b1, 2'b10, 6'd12, mk(32'h1, 32'h20), 1'b0, '0);
    idle();
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd11);
    checks++;
    if (rd_data !== mk(32'h1234, 32'h10)) begin
      errors++; $display("FAIL add_wrap_lane: got %h expected %h", rd_data, mk(32'h1234, 32'h10));
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd12);
    checks++;
    if (rd_data !== mk(32'h1235, 32'hFFFF_FFFF)) begin
      errors++; $display("FAIL add_sat_lane: got %h expected %h", rd_data, mk(32'h1235, 32'hFFFF_FFFF));
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 2'b00, 6'd7, mk(32'hA, 32'hA0), 1'b0, '0);
    drive(1'b1, 2'b00, 6'd7, mk(32'hB, 32'hB0), 1'b1, 6'd7);
    checks++;
    if (rd_data !== mk(32'hA, 32'hA0)) begin
      errors++; $display("FAIL collide_same_cycle: got %h expected %h", rd_data, mk(32'hA, 32'hA0));
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd7);
    checks++;
    if (rd_data !== mk(32'hB, 32'hB0)) begin
      errors++; $display("FAIL collide_next_cycle: got %h expected %h", rd_data, mk(32'hB, 32'hB0));
    end
  endtask

  task automatic test_clear_concurrent();
    drive(1'b1, 2'b00, 6'd2, mk(32'hC2, 32'hC1), 1'b0, '0);
    drive(1'b1, 2'b00, 6'd9, mk(32'hD2, 32'hD1), 1'b0, '0);
    drive(1'b1, 2'b11, 6'd9, mk(32'hDEAD, 32'hBEEF), 1'b1, 6'd2);
    checks++;
    if (rd_data !== mk(32'hC2, 32'hC1)) begin
      errors++; $display("FAIL clear_other_read: got %h expected %h", rd_data, mk(32'hC2, 32'hC1));
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd9);
    checks++;
    if (rd_data !== '0) begin
      errors++; $display("FAIL clear_result: got %h expected 0", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'b00, 6'd4, mk(32'h0, 32'h1), 1'b0, '0);
    idle();
    drive(1'b1, 2'b01, 6'd4, mk(32'h0, 32'h1), 1'b0, '0);
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd4);
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_valid: got %b expected 0", rd_valid);
    end
    rst_n = 1'b1;
    drive(1'b0, 2'b00, '0, '0, 1'b1, 6'd4);
    checks++;
    if (rd_data !== mk(32'h0, 32'h1)) begin
      errors++; $display("FAIL midreset_dropped: got %h expected %h", rd_data, mk(32'h0, 32'h1));
    end
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_read_valid: got %b expected 1", rd_valid);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_mode = 2'b00;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    test_reset();
    test_overwrite();
    test_back_to_back();
    test_saturation();
    test_collision();
    test_clear_concurrent();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
